// File: rtl/carry_select_accum.sv
// Block accumulator for carry-select adder results.
// Sums up to BLOCK_LEN samples and presents each block sum with its sample count.
module carry_select_accum #(
  parameter int DATA_WIDTH = 24,
  parameter int BLOCK_LEN  = 8,
  localparam int LOG_LEN   = $clog2(BLOCK_LEN),
  localparam int SUM_WIDTH = DATA_WIDTH + 1 + LOG_LEN,
  localparam int CNT_WIDTH = LOG_LEN + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SUM_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]  out_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               r_state;
  logic [SUM_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_out_valid;
  logic [SUM_WIDTH-1:0] r_out_sum;
  logic [CNT_WIDTH-1:0] r_out_count;

  logic                 w_accept;
  logic                 w_close;
  logic [SUM_WIDTH-1:0] w_acc_next;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [SUM_WIDTH-1:0] w_close_sum;
  logic [CNT_WIDTH-1:0] w_close_cnt;

  assign in_ready  = !rst && (r_state == ACCUM);
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;

  assign w_accept   = in_valid && in_ready;
  assign w_acc_next = r_acc + {{LOG_LEN{1'b0}}, in_data};
  assign w_cnt_next = r_cnt + 1'b1;

  // A flushed empty block produces nothing; a sample arriving with flush joins it.
  always_comb begin
    w_close     = 1'b0;
    w_close_sum = r_acc;
    w_close_cnt = r_cnt;
    if (w_accept) begin
      w_close     = flush || (w_cnt_next == CNT_WIDTH'(BLOCK_LEN));
      w_close_sum = w_acc_next;
      w_close_cnt = w_cnt_next;
    end else begin
      w_close = flush && (r_cnt != '0) && (r_state == ACCUM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_close) begin
            r_out_sum   <= w_close_sum;
            r_out_count <= w_close_cnt;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_state     <= HOLD;
          end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/carry_select_accum.md
CARRY_SELECT_ACCUM -- requirements
Module: carry_select_accum

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 24, the adder operand width; the input sample is DATA_WIDTH+1 bits wide (sum plus carry-out).
REQ-002 SHALL provide parameter BLOCK_LEN, default 8, the number of samples per accumulation block; it SHALL be a power of two, at least 2.
REQ-003 SHALL derive SUM_WIDTH = DATA_WIDTH+1+log2(BLOCK_LEN), default 28, and CNT_WIDTH = log2(BLOCK_LEN)+1, default 4.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  upstream adder result present.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 in_data  input  DATA_WIDTH+1  unsigned adder result (carry in MSB).
REQ-010 flush  input  1  close the current block early.
REQ-011 out_valid  output  1  block sum available.
REQ-012 out_ready  input  1  downstream accepts the block sum.
REQ-013 out_sum  output  SUM_WIDTH  unsigned sum of the block's samples.
REQ-014 out_count  output  CNT_WIDTH  number of samples in out_sum, 1..BLOCK_LEN.

Function
REQ-015 SHALL implement two states: ACCUM (collecting) and HOLD (presenting a result).
REQ-016 SHALL assert in_ready in ACCUM only; the block SHALL accept a sample when in_valid and in_ready are both high at a rising edge.
REQ-017 On each accepted sample, SHALL add in_data, zero-extended, to an internal SUM_WIDTH accumulator and increment an internal sample counter; no truncation or wrap SHALL be possible.
REQ-018 When the accepted sample makes the count equal BLOCK_LEN, SHALL register out_sum = accumulator + in_data and out_count = BLOCK_LEN, set out_valid, clear the accumulator and counter, and enter HOLD.
REQ-019 Latency: out_valid SHALL be high the cycle after the final accepted sample.
REQ-020 flush in ACCUM with count > 0 SHALL close the block with the partial sum and count, exactly as REQ-018.
REQ-021 flush coinciding with an accepted sample SHALL include that sample in the closed block; if that sample also completes BLOCK_LEN, the result SHALL be identical to a normal completion.
REQ-022 flush in ACCUM with count 0 and no accepted sample SHALL be ignored, with no output produced.
REQ-023 flush in HOLD SHALL be ignored and not remembered.
REQ-024 In HOLD, out_valid, out_sum and out_count SHALL stay stable until out_valid and out_ready are both high at a rising edge; the block SHALL then deassert out_valid and return to ACCUM on that edge.
REQ-025 in_valid and in_data SHALL be ignored while in HOLD; idle cycles with in_valid low SHALL not affect the accumulator.
REQ-026 Minimum block period SHALL be BLOCK_LEN+1 cycles with out_ready held high.
REQ-027 out_sum and out_count SHALL keep their last values after a handshake until the next block closes.

Reset
REQ-028 rst high SHALL immediately, without a clock edge, force state ACCUM, accumulator 0, counter 0, out_valid 0, out_sum 0 and out_count 0; in_ready SHALL be 1 while rst is low and the state is ACCUM.
REQ-029 Reset mid-block or in HOLD SHALL discard all partial and pending data, and no residue SHALL appear in later blocks.

Verification
REQ-030 8 back-to-back samples of 1, out_ready=1 -> out_valid high one cycle after the 8th accept, out_sum=8, out_count=8, in_ready=0 that cycle and 1 the next.
REQ-031 8 samples of 33554431 (0x1FFFFFF) -> out_sum=268435448 (0xFFFFFF8), out_count=8.
REQ-032 Complete a block with out_ready=0 for 5 cycles while driving in_valid=1 -> out_valid, out_sum and out_count stable, in_ready=0, no sample absorbed; raise out_ready -> exactly one transfer, then ACCUM.
REQ-033 Samples 10, 20, 30 then flush -> out_sum=60, count 3; next block 10, 20, 30 plus 40 with flush in the same cycle -> out_sum=100, count 4; flush at count 0 -> no out_valid.
REQ-034 5 samples accepted, then rst pulsed between edges -> all outputs 0 immediately; then 8 samples of 2 -> out_sum=16, count 8.
REQ-035 8 samples of 5 with random in_valid gaps of 0-3 cycles -> out_sum=40, count 8.
